// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue and committed after a fixed busy latency.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_valid_q, pend_valid_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] abs_a, abs_b, sdiv_b, udiv_b;
  logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;

  // Signed ops work on magnitudes; a zero divisor is swapped for 1 so the
  // dividers never see it, and the result is simply not committed.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_neg  = A[31];
    b_neg  = B[31];
    b_zero = (B == 32'd0);
    abs_a  = a_neg ? (32'd0 - A) : A;
    abs_b  = b_neg ? (32'd0 - B) : B;
    sdiv_b = b_zero ? 32'd1 : abs_b;
    udiv_b = b_zero ? 32'd1 : B;
    uq_s   = abs_a / sdiv_b;
    ur_s   = abs_a % sdiv_b;
    q_s    = (a_neg ^ b_neg) ? (32'd0 - uq_s) : uq_s;
    r_s    = a_neg ? (32'd0 - ur_s) : ur_s;
    q_u    = A / udiv_b;
    r_u    = A % udiv_b;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_valid_d = 1'b1;
              cnt_d        = CNT_W'(MUL_CYCLES);
              state_d      = RUN;
            end
            3'b001: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_valid_d = 1'b1;
              cnt_d        = CNT_W'(MUL_CYCLES);
              state_d      = RUN;
            end
            3'b010: begin
              pend_hi_d    = r_s;
              pend_lo_d    = q_s;
              pend_valid_d = !b_zero;
              cnt_d        = CNT_W'(DIV_CYCLES);
              state_d      = RUN;
            end
            3'b011: begin
              pend_hi_d    = r_u;
              pend_lo_d    = q_u;
              pend_valid_d = !b_zero;
              cnt_d        = CNT_W'(DIV_CYCLES);
              state_d      = RUN;
            end
            3'b100: hi_d = A;
            3'b101: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results and busy
// lengths for every op, divide-by-zero, overflow, ignored starts and reset.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;
  int cycles;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_RSVD  = 3'b110;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one operation for exactly one clock edge; returns at the
  // following falling edge with start already low.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy-high cycles from the current falling edge; stops at the
  // first cycle busy is low or after a generous bound.
  task automatic waitBusy(input int already, output int n);
    n = already;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 3'b000;
    A        = '0;
    B        = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    rst_n = 1'b1;

    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checkOutput("mult busy mid", HI, 32'd0);
    waitBusy(0, cycles);
    checkOutput("mult cycles", 32'(cycles), 32'd5);
    checkOutput("mult HI", HI, 32'hFFFF_FFFF);
    checkOutput("mult LO", LO, 32'hFFFF_FFFA);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitBusy(0, cycles);
    checkOutput("multu cycles", 32'(cycles), 32'd5);
    checkOutput("multu HI", HI, 32'hFFFF_FFFE);
    checkOutput("multu LO", LO, 32'h0000_0001);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitBusy(0, cycles);
    checkOutput("div cycles", 32'(cycles), 32'd10);
    checkOutput("div LO", LO, 32'hFFFF_FFFD);
    checkOutput("div HI", HI, 32'hFFFF_FFFF);

    applyStimulus(OP_DIVU, 32'd7, 32'd2);
    waitBusy(0, cycles);
    checkOutput("divu LO", LO, 32'd3);
    checkOutput("divu HI", HI, 32'd1);

    applyStimulus(OP_MTHI, 32'h0000_1234, 32'd0);
    checkOutput("mthi busy", {31'd0, busy}, 32'd0);
    checkOutput("mthi HI", HI, 32'h0000_1234);
    applyStimulus(OP_MTLO, 32'h0000_5678, 32'd0);
    checkOutput("mtlo LO", LO, 32'h0000_5678);
    checkOutput("mtlo HI kept", HI, 32'h0000_1234);

    applyStimulus(OP_DIVU, 32'd99, 32'd0);
    waitBusy(0, cycles);
    checkOutput("div0 cycles", 32'(cycles), 32'd10);
    checkOutput("div0 HI", HI, 32'h0000_1234);
    checkOutput("div0 LO", LO, 32'h0000_5678);

    applyStimulus(OP_RSVD, 32'hAAAA_AAAA, 32'd5);
    checkOutput("rsvd busy", {31'd0, busy}, 32'd0);
    checkOutput("rsvd HI", HI, 32'h0000_1234);
    checkOutput("rsvd LO", LO, 32'h0000_5678);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitBusy(0, cycles);
    checkOutput("ovf LO", LO, 32'h8000_0000);
    checkOutput("ovf HI", HI, 32'd0);

    // A MULTU issued while a DIVU is running must leave no trace.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    start = 1'b1;
    op    = OP_MULTU;
    A     = 32'd5;
    B     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    waitBusy(1, cycles);
    checkOutput("ignore cycles", 32'(cycles), 32'd10);
    checkOutput("ignore LO", LO, 32'd14);
    checkOutput("ignore HI", HI, 32'd2);

    // Reset in the third busy cycle of a MULT, after an ignored MTLO.
    applyStimulus(OP_MULT, 32'd2, 32'd3);
    start = 1'b1;
    op    = OP_MTLO;
    A     = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy mtlo LO", LO, 32'd14);
    @(negedge clk);
    checkOutput("busy c3", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async busy", {31'd0, busy}, 32'd0);
    checkOutput("async HI", HI, 32'd0);
    checkOutput("async LO", LO, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("no commit busy", {31'd0, busy}, 32'd0);
    checkOutput("no commit HI", HI, 32'd0);
    checkOutput("no commit LO", LO, 32'd0);

    applyStimulus(OP_MULTU, 32'd6, 32'd7);
    waitBusy(0, cycles);
    checkOutput("post reset cycles", 32'(cycles), 32'd5);
    checkOutput("post reset LO", LO, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide responder for the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO operations issued from the EX stage by the decode/control path.
- Holds the architectural HI/LO registers and raises busy so the hazard logic can stall any MDU-dependent instruction.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue strobe, one cycle per operation
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved, no effect
- A  input  32  rs operand
- B  input  32  rt operand
- busy  output  1  high while a mult/div is in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - busy=0, HI=0, LO=0, counter=0, pending result discarded.
  - Operation resumes normally on the first clk edge after rst_n rises.
- States are IDLE and RUN; an internal down-counter and pending HI/LO registers accompany RUN.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - Compute result from A/B at this edge and latch it into the pending registers.
  - Load counter with MUL_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0, HI/LO take the pending values, busy drops to 0, state returns to IDLE.
  - busy is therefore high for exactly N cycles; HI/LO become visible in the first cycle busy is low.
- Arithmetic:
  - MULT: {HI,LO} = signed(A)*signed(B), 64-bit.
  - MULTU: {HI,LO} = unsigned(A)*unsigned(B).
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned LO = A/B, HI = A%B.
- Divide by zero (B=0): operation runs the full DIV_CYCLES, but HI/LO are left unchanged at completion.
- Signed overflow case (A=0x80000000, B=0xFFFFFFFF, DIV): LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE with start=1: HI (or LO) takes A at that edge; busy stays 0; no latency.
- start=1 while busy=1: ignored entirely; in-flight result unaffected. Preventing this is the hazard unit's job.
- start=1 in the same cycle busy falls (counter reaching 0): not possible, because busy is still 1 that cycle, so start is ignored.
- The first accepted start is in the cycle after busy=0 is observed.
- Reserved op codes with start=1: no state change.
- HI/LO outputs are registered, never combinational from A/B.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x1234 then MTLO A=0x5678, then DIVU B=0 -> HI=0x1234, LO=0x5678 unchanged after 10 busy cycles.
- Start MULT 2*3, issue MTLO A=0xDEAD during busy, then assert rst_n=0 in busy cycle 3 -> MTLO ignored; busy=0 and HI=LO=0 immediately, with no later commit.
